// File: rtl/huffman_bit_packer.sv
// ---------------------------------------------------------------------------
// huffman_bit_packer
//
// Sits downstream of the Huffman code generator. When code_valid pulses it
// captures the six codewords (masked to their length) and the code lengths.
// It then encodes a stream of gray symbols (1..6) into an MSB-first
// bitstream and hands it out as bytes on a valid/ready interface. The final
// byte is zero-padded and flagged with out_last, and done pulses for one
// cycle once the stream has fully drained.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   code_valid          : one-cycle pulse, HC1..HC6 / M1..M6 valid
//   HC1..HC6            : right-aligned codewords for symbols 1..6
//   M1..M6              : contiguous-ones masks; code length = popcount
//   sym_valid/ready     : symbol handshake, sym_data = symbol,
//                         sym_last marks the final symbol of a stream
//   out_valid/ready     : byte handshake, out_data = packed byte
//                         (first coded bit in bit7), out_last = final byte
//   done                : one-cycle pulse, stream fully drained
//   err                 : sticky, an out-of-range symbol was seen
//   total_bits          : code bits packed this stream, padding excluded
// ---------------------------------------------------------------------------
module huffman_bit_packer #(
    parameter int TB_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            code_valid,
    input  logic [7:0]      HC1,
    input  logic [7:0]      HC2,
    input  logic [7:0]      HC3,
    input  logic [7:0]      HC4,
    input  logic [7:0]      HC5,
    input  logic [7:0]      HC6,
    input  logic [7:0]      M1,
    input  logic [7:0]      M2,
    input  logic [7:0]      M3,
    input  logic [7:0]      M4,
    input  logic [7:0]      M5,
    input  logic [7:0]      M6,
    input  logic            sym_valid,
    input  logic [7:0]      sym_data,
    input  logic            sym_last,
    output logic            sym_ready,
    output logic            out_valid,
    output logic [7:0]      out_data,
    output logic            out_last,
    input  logic            out_ready,
    output logic            done,
    output logic            err,
    output logic [TB_W-1:0] total_bits
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t            state_q, state_d;
    logic [15:0]       bits_q, bits_d;
    logic [4:0]        fill_q, fill_d;
    logic [7:0]        hc_q  [1:6];
    logic [7:0]        hc_d  [1:6];
    logic [3:0]        len_q [1:6];
    logic [3:0]        len_d [1:6];
    logic              err_q, err_d;
    logic [TB_W-1:0]   total_q, total_d;

    logic [7:0]        hc_in [1:6];
    logic [7:0]        m_in  [1:6];
    logic              accept, pop, sym_in_range;
    logic [7:0]        sel_hc;
    logic [3:0]        sel_len;
    logic [15:0]       ins_bits;

    function automatic logic [3:0] popcount(input logic [7:0] m);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, m[i]};
        end
        return c;
    endfunction

    assign hc_in[1] = HC1;
    assign hc_in[2] = HC2;
    assign hc_in[3] = HC3;
    assign hc_in[4] = HC4;
    assign hc_in[5] = HC5;
    assign hc_in[6] = HC6;
    assign m_in[1]  = M1;
    assign m_in[2]  = M2;
    assign m_in[3]  = M3;
    assign m_in[4]  = M4;
    assign m_in[5]  = M5;
    assign m_in[6]  = M6;

    // Handshake outputs depend only on registered state, never on inputs.
    // Accept needs fill < 8 and pop needs fill >= 8, so in RUN the two can
    // never coincide and the buffer update has a single source per cycle.
    assign sym_ready  = (state_q == RUN) && (fill_q < 5'd8);
    assign out_valid  = ((state_q == RUN) && (fill_q >= 5'd8)) ||
                        ((state_q == FLUSH) && (fill_q != 5'd0));
    assign out_last   = (state_q == FLUSH) && (fill_q != 5'd0) && (fill_q <= 5'd8);
    assign out_data   = bits_q[15:8];
    assign done       = (state_q == DONE);
    assign err        = err_q;
    assign total_bits = total_q;

    assign accept = sym_valid && sym_ready;
    assign pop    = out_valid && out_ready;

    // Look up the latched code for the offered symbol. Out-of-range symbols
    // select nothing, so they contribute no bits.
    always_comb begin
        sym_in_range = 1'b0;
        sel_hc       = 8'd0;
        sel_len      = 4'd0;
        for (int k = 1; k <= 6; k++) begin
            if (sym_data == 8'(k)) begin
                sym_in_range = 1'b1;
                sel_hc       = hc_q[k];
                sel_len      = len_q[k];
            end
        end
        // Left-align the code at bit 15, then slide it down past the bits
        // already held. fill <= 7 and len <= 8 keeps it inside the buffer.
        ins_bits = ({sel_hc, 8'h00} << (4'd8 - sel_len)) >> fill_q;
    end

    // Next-state logic for the packer: code capture, symbol insertion,
    // byte pops, and the flush of the final partial byte.
    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        fill_d  = fill_q;
        hc_d    = hc_q;
        len_d   = len_q;
        err_d   = err_q;
        total_d = total_q;

        case (state_q)
            IDLE: begin
                if (code_valid) begin
                    for (int k = 1; k <= 6; k++) begin
                        hc_d[k]  = hc_in[k] & m_in[k];
                        len_d[k] = popcount(m_in[k]);
                    end
                    err_d   = 1'b0;
                    total_d = '0;
                    bits_d  = 16'd0;
                    fill_d  = 5'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (sym_in_range) begin
                        bits_d  = bits_q | ins_bits;
                        fill_d  = fill_q + {1'b0, sel_len};
                        total_d = total_q + TB_W'(sel_len);
                    end else begin
                        err_d = 1'b1;
                    end
                    // An empty stream has nothing to flush.
                    if (sym_last) begin
                        state_d = (fill_d == 5'd0) ? DONE : FLUSH;
                    end
                end else if (pop) begin
                    bits_d = {bits_q[7:0], 8'h00};
                    fill_d = fill_q - 5'd8;
                end
            end
            FLUSH: begin
                if (fill_q == 5'd0) begin
                    state_d = DONE;
                end else if (pop) begin
                    if (fill_q <= 5'd8) begin
                        bits_d  = 16'd0;
                        fill_d  = 5'd0;
                        state_d = DONE;
                    end else begin
                        bits_d = {bits_q[7:0], 8'h00};
                        fill_d = fill_q - 5'd8;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset drops any buffered bits
    // and any byte that was waiting to be consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bits_q  <= 16'd0;
            fill_q  <= 5'd0;
            err_q   <= 1'b0;
            total_q <= '0;
            for (int k = 1; k <= 6; k++) begin
                hc_q[k]  <= 8'd0;
                len_q[k] <= 4'd0;
            end
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            fill_q  <= fill_d;
            err_q   <= err_d;
            total_q <= total_d;
            for (int k = 1; k <= 6; k++) begin
                hc_q[k]  <= hc_d[k];
                len_q[k] <= len_d[k];
            end
        end
    end

endmodule

// File: tb/tb_huffman_bit_packer.sv
// ---------------------------------------------------------------------------
// tb_huffman_bit_packer
//
// Self-checking bench for huffman_bit_packer. Each stream is encoded by a
// reference model that builds the bitstream as a plain queue of bits and
// chops it into bytes; the expected bytes and end-of-stream results are
// queued, and a monitor pops and compares them as the DUT presents them.
// ---------------------------------------------------------------------------
module tb_huffman_bit_packer;

    localparam int TB_W = 16;

    logic            clk;
    logic            reset;
    logic            code_valid;
    logic [7:0]      hc_drv [1:6];
    logic [7:0]      m_drv  [1:6];
    logic            sym_valid;
    logic [7:0]      sym_data;
    logic            sym_last;
    logic            sym_ready;
    logic            out_valid;
    logic [7:0]      out_data;
    logic            out_last;
    logic            out_ready;
    logic            done;
    logic            err;
    logic [TB_W-1:0] total_bits;

    int checks = 0;
    int errors = 0;

    logic [8:0]  exp_bytes [$];
    logic [16:0] exp_done  [$];
    logic [7:0]  sym_q     [$];

    bit          rand_ready = 1'b0;
    bit          held_valid = 1'b0;
    logic [8:0]  held_byte;
    bit          prev_done  = 1'b0;

    huffman_bit_packer #(.TB_W(TB_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .HC1        (hc_drv[1]),
        .HC2        (hc_drv[2]),
        .HC3        (hc_drv[3]),
        .HC4        (hc_drv[4]),
        .HC5        (hc_drv[5]),
        .HC6        (hc_drv[6]),
        .M1         (m_drv[1]),
        .M2         (m_drv[2]),
        .M3         (m_drv[3]),
        .M4         (m_drv[4]),
        .M5         (m_drv[5]),
        .M6         (m_drv[6]),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_last   (sym_last),
        .sym_ready  (sym_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .done       (done),
        .err        (err),
        .total_bits (total_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports a FAIL line on mismatch.
    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endfunction

    // Reference model: concatenate the codes of the queued symbols MSB first,
    // then cut the bit list into zero-padded bytes.
    task automatic modelStream();
        bit          bitlist [$];
        bit          bad;
        int          n, nbytes, l, idx;
        logic [7:0]  val;
        logic [7:0]  s;
        bad = 1'b0;
        foreach (sym_q[i]) begin
            s = sym_q[i];
            if (s >= 8'd1 && s <= 8'd6) begin
                l = $countones(m_drv[s]);
                for (int b = l - 1; b >= 0; b--) bitlist.push_back(hc_drv[s][b]);
            end else begin
                bad = 1'b1;
            end
        end
        n = bitlist.size();
        nbytes = (n + 7) / 8;
        for (int b = 0; b < nbytes; b++) begin
            val = 8'h00;
            for (int j = 0; j < 8; j++) begin
                idx = b * 8 + j;
                if (idx < n) val[7-j] = bitlist[idx];
            end
            exp_bytes.push_back({(b == nbytes - 1), val});
        end
        exp_done.push_back({bad, 16'(n)});
    endtask

    task automatic setTestTable();
        logic [7:0] hcs [6];
        logic [7:0] ms  [6];
        hcs = '{8'b0, 8'b10, 8'b110, 8'b1110, 8'b11110, 8'b11111};
        ms  = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd31, 8'd31};
        for (int k = 1; k <= 6; k++) begin
            hc_drv[k] = hcs[k-1];
            m_drv[k]  = ms[k-1];
        end
    endtask

    task automatic setRandomTable();
        int l;
        for (int k = 1; k <= 6; k++) begin
            l = $urandom_range(1, 8);
            m_drv[k]  = 8'((1 << l) - 1);
            hc_drv[k] = 8'($urandom);
        end
    endtask

    // Loads the current table, offers every symbol in sym_q, and optionally
    // waits for the done pulse. All waits are bounded.
    task automatic applyStimulus(input bit wait_done);
        int  cyc;
        bit  ok;
        modelStream();
        @(posedge clk); #1;
        code_valid = 1'b1;
        @(posedge clk); #1;
        code_valid = 1'b0;
        foreach (sym_q[i]) begin
            sym_valid = 1'b1;
            sym_data  = sym_q[i];
            sym_last  = (i == sym_q.size() - 1);
            ok  = 1'b0;
            cyc = 0;
            while (!ok && cyc < 300) begin
                @(negedge clk);
                if (sym_ready) ok = 1'b1;
                cyc++;
            end
            if (!ok) begin
                checkOutput("sym_accept_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk); #1;
        end
        sym_valid = 1'b0;
        sym_last  = 1'b0;
        sym_data  = 8'd0;
        if (wait_done) begin
            ok  = 1'b0;
            cyc = 0;
            while (!ok && cyc < 600) begin
                @(negedge clk);
                if (done) ok = 1'b1;
                cyc++;
            end
            if (!ok) checkOutput("done_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
        end
    endtask

    // Random backpressure on the byte interface when enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compares each consumed byte and each done pulse against the
    // scoreboard, and checks that a stalled byte holds steady.
    always @(negedge clk) begin
        if (reset) begin
            held_valid = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (held_valid) begin
                checkOutput("stall_hold", {23'd0, out_valid, out_last, out_data},
                            {23'd0, 1'b1, held_byte});
            end
            held_valid = out_valid && !out_ready;
            held_byte  = {out_last, out_data};

            if (out_valid && out_ready) begin
                if (exp_bytes.size() == 0) begin
                    checkOutput("unexpected_byte", {23'd0, out_last, out_data}, 32'h1ff);
                end else begin
                    checkOutput("byte", {23'd0, out_last, out_data}, {23'd0, exp_bytes.pop_front()});
                end
            end

            if (done) begin
                checkOutput("done_single", {31'd0, prev_done}, 32'd0);
                checkOutput("bytes_drained", exp_bytes.size(), 32'd0);
                if (exp_done.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    checkOutput("err_total", {15'd0, err, total_bits}, {15'd0, exp_done.pop_front()});
                end
            end
            prev_done = done;
        end
    end

    initial begin
        reset      = 1'b1;
        code_valid = 1'b0;
        sym_valid  = 1'b0;
        sym_data   = 8'd0;
        sym_last   = 1'b0;
        out_ready  = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            hc_drv[k] = 8'd0;
            m_drv[k]  = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_sym_ready", {31'd0, sym_ready}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        checkOutput("rst_total", {16'd0, total_bits}, 32'd0);
        checkOutput("rst_out_last", {31'd0, out_last}, 32'd0);

        // Basic stream: 0,10,110,1110 -> 0x5B, 0x80(last), 10 bits.
        setTestTable();
        sym_q.delete();
        sym_q.push_back(8'd1); sym_q.push_back(8'd2);
        sym_q.push_back(8'd3); sym_q.push_back(8'd4);
        applyStimulus(1'b1);

        // Exactly one full byte: no padding byte afterwards.
        sym_q.delete();
        for (int i = 0; i < 8; i++) sym_q.push_back(8'd1);
        applyStimulus(1'b1);

        // Backpressure: output held at 0xFF with symbol input closed.
        sym_q.delete();
        for (int i = 0; i < 4; i++) sym_q.push_back(8'd6);
        out_ready = 1'b0;
        fork
            applyStimulus(1'b1);
            begin
                int  cyc;
                bit  seen;
                seen = 1'b0;
                cyc  = 0;
                while (!seen && cyc < 50) begin
                    @(negedge clk);
                    if (out_valid) seen = 1'b1;
                    cyc++;
                end
                checkOutput("stall_seen", {31'd0, seen}, 32'd1);
                repeat (10) begin
                    @(negedge clk);
                    checkOutput("stall_valid_data", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'hFF});
                    checkOutput("stall_sym_ready", {31'd0, sym_ready}, 32'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join

        // Out-of-range symbols around a valid one.
        sym_q.delete();
        sym_q.push_back(8'd0); sym_q.push_back(8'd1); sym_q.push_back(8'd9);
        applyStimulus(1'b1);

        // Only an invalid symbol: no bytes, just done with err.
        sym_q.delete();
        sym_q.push_back(8'd7);
        applyStimulus(1'b1);

        // Reset while a flush byte is pending.
        sym_q.delete();
        sym_q.push_back(8'd6); sym_q.push_back(8'd6);
        out_ready = 1'b0;
        applyStimulus(1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        exp_bytes.delete();
        exp_done.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_sym_ready", {31'd0, sym_ready}, 32'd0);
        checkOutput("midrst_done", {31'd0, done}, 32'd0);
        out_ready = 1'b1;
        sym_q.delete();
        sym_q.push_back(8'd2);
        applyStimulus(1'b1);

        // Randomized tables, symbol streams and backpressure.
        for (int s = 0; s < 25; s++) begin
            int n, r;
            setRandomTable();
            sym_q.delete();
            n = $urandom_range(1, 14);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 9);
                if (r < 8)       sym_q.push_back(8'($urandom_range(1, 6)));
                else if (r == 8) sym_q.push_back(8'd0);
                else             sym_q.push_back(8'($urandom_range(7, 255)));
            end
            rand_ready = 1'b1;
            applyStimulus(1'b1);
            rand_ready = 1'b0;
            out_ready  = 1'b1;
        end

        repeat (5) @(posedge clk);
        checkOutput("final_bytes_empty", exp_bytes.size(), 32'd0);
        checkOutput("final_done_empty", exp_done.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/huffman_bit_packer.md
Name: huffman_bit_packer

Overview:
- Downstream consumer of the Huffman code generator.
- On the generator's code_valid pulse it latches the six codewords and masks.
- It then encodes a replayed stream of gray symbols (values 1..6) into an MSB-first bitstream and emits it as 8-bit bytes on a valid/ready interface.
- The last byte is zero-padded and flagged; a one-cycle done pulse ends each stream.

Parameters:
- TB_W, 16, width of the total-bit counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- code_valid  in  1  one-cycle pulse: HC1..HC6/M1..M6 valid this cycle
- HC1..HC6  in  8 each  codeword for symbol k, right-aligned
- M1..M6  in  8 each  mask for symbol k, contiguous ones from bit0; code length = popcount, 1..8
- sym_valid  in  1  symbol offered
- sym_data  in  8  gray symbol
- sym_last  in  1  qualifies the final symbol of the stream
- sym_ready  out  1  symbol accepted when sym_valid & sym_ready
- out_valid  out  1  byte available
- out_data  out  8  packed byte; first-coded bit in bit7
- out_last  out  1  qualifies the final byte
- out_ready  in  1  byte consumed when out_valid & out_ready
- done  out  1  one-cycle pulse, stream fully drained
- err  out  1  sticky: an out-of-range symbol was seen this stream
- total_bits  out  TB_W  code bits packed this stream, excluding padding

Behaviour:
- Reset values: state=IDLE; all outputs 0; latched codes/lengths 0; buffer, fill, total_bits 0.
- Reset mid-operation discards the buffer and any pending byte. out_valid and sym_ready are 0 in the cycle after reset.
- Storage:
  - 16-bit left-aligned bit buffer buf.
  - 5-bit fill, range 0..15.
  - Per-symbol latched HC and len, where len = popcount(M).
- IDLE:
  - sym_ready=0.
  - On code_valid: latch all HC/len, clear err and total_bits, go to RUN next cycle.
- RUN:
  - sym_ready = (fill < 8).
  - out_valid = (fill >= 8), so accept and pop never occur in the same cycle.
  - Accept of symbol k in 1..6: the low len bits of HC_k are inserted at buf positions [15-fill -: len], MSB of the code first. Then fill += len and total_bits += len, both visible the next cycle.
  - Accept of a symbol outside 1..6: no bits are inserted; err is set from the next cycle.
  - Pop (out_valid & out_ready): out_data = buf[15:8]; buf shifts left by 8 with zero fill; fill -= 8.
  - With out_ready low, out_data and out_valid hold stable.
  - Accept with sym_last=1 moves to FLUSH next cycle, after the buffer update.
  - code_valid in RUN or FLUSH is ignored.
- FLUSH:
  - sym_ready=0.
  - out_valid = (fill > 0).
  - out_data = buf[15:8], with unused low bits already 0.
  - out_last = (fill <= 8) while out_valid.
  - A pop with fill <= 8 sets fill to 0 and moves to DONE.
  - On entry with fill == 0, go directly to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - err and total_bits hold until the next code_valid.
- Latency: a symbol accepted at edge t can produce a byte with out_valid high in cycle t+1.
- Overflow: fill never exceeds 15, because an accept requires fill ≤ 7 and len ≤ 8. total_bits wraps modulo 2^TB_W.

Test Plan:
- Table HC1..HC6=0,10,110,1110,11110,11111 (binary) with M=1,3,7,15,31,31. Symbols 1,2,3,4 (last on 4), out_ready=1 → bytes 0x5B then 0x80 with out_last on 0x80; total_bits=10; done pulses once.
- Same table, eight symbol-1s (last on the 8th) → exactly one byte 0x00 with out_last=1; no pad byte; total_bits=8.
- Symbols 6,6,6,6 with out_ready=0 for 10 cycles:
  - out_valid=1 with out_data=0xFF stays stable throughout.
  - sym_ready stays 0 while fill ≥ 8.
  - After release, bytes are 0xFF, 0xFF, 0xF0 (last).
- Symbols 0, 1, 9 (last on 9) → err=1; one byte 0x00 with out_last; total_bits=1.
- Only symbol 7, with last → no byte output; done pulses; err=1; total_bits=0.
- Assert reset during FLUSH with a byte pending → next cycle out_valid=0, sym_ready=0, state IDLE. A new code_valid followed by symbol 2 (last) → byte 0x80 with out_last.
